// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential signed binary to 7-segment digit codes via shift-add-3
module bin_to_bcd_seq #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] digits,
  output logic [3:0]          sign_code
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t                state, state_d;
  logic [WIDTH-1:0]      mag;
  logic [4*DIGITS-1:0]   bcd, adj, fmt;
  logic [CW-1:0]         count;
  logic                  sign, seen;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    if (state == IDLE && start) state_d = SHIFT;
    else if (state == SHIFT && count == CW'(WIDTH - 1)) state_d = FORMAT;
    else if (state == FORMAT) state_d = IDLE;
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // Walk down from the top nibble; everything above the first nonzero digit is blanked
  always_comb begin
    seen = 1'b0;
    fmt  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (bcd[4*i +: 4] != 4'd0) | (i == 0);
      fmt[4*i +: 4] = (BLANK_LZ != 0 && !seen) ? 4'hF : bcd[4*i +: 4];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mag       <= '0;
      bcd       <= '0;
      count     <= '0;
      sign      <= 1'b0;
      done      <= 1'b0;
      digits    <= '1;
      sign_code <= 4'hF;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        sign  <= value[WIDTH-1];
        mag   <= value[WIDTH-1] ? -value : value;
        bcd   <= '0;
        count <= '0;
      end else if (state == SHIFT) begin
        {bcd, mag} <= {adj, mag} << 1;
        count      <= count + CW'(1);
      end else if (state == FORMAT) begin
        digits    <= fmt;
        sign_code <= sign ? 4'd11 : 4'hF;
        done      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq (blanking and non-blanking instances)
module tb_bin_to_bcd_seq;
  typedef struct packed {
    logic [19:0] d1;
    logic [19:0] d0;
    logic [3:0]  s;
  } exp_t;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] value = '0;
  logic        busy, done, busy0, done0;
  logic [19:0] digits, digits0;
  logic [3:0]  sign_code, sign0;
  int          checks = 0, errors = 0, done_cnt = 0;
  exp_t        sb[$];
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .digits(digits), .sign_code(sign_code)
  );
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .busy(busy0), .done(done0), .digits(digits0), .sign_code(sign0)
  );
  always #5 clock = ~clock;
  function automatic exp_t model(input logic [15:0] v);
    int m, nd, t;
    exp_t e;
    m = $signed(v);
    if (m < 0) m = -m;
    t = m;
    nd = 1;
    while (t >= 10) begin t /= 10; nd++; end
    t = m;
    for (int i = 0; i < 5; i++) begin
      e.d0[4*i +: 4] = 4'(t % 10);
      e.d1[4*i +: 4] = (i >= nd) ? 4'hF : 4'(t % 10);
      t /= 10;
    end
    e.s = ($signed(v) < 0) ? 4'd11 : 4'hF;
    return e;
  endfunction
  always @(negedge clock) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: digits=%h sign=%h, required no done", digits, sign_code);
      end else begin
        e = sb.pop_front();
        if (digits !== e.d1 || sign_code !== e.s) begin
          errors++;
          $display("FAIL result_blank: got %h/%h, required %h/%h", digits, sign_code, e.d1, e.s);
        end
        checks++;
        if (digits0 !== e.d0 || sign0 !== e.s || done0 !== 1'b1) begin
          errors++;
          $display("FAIL result_noblank: got %h/%h done0=%b, required %h/%h done0=1",
                   digits0, sign0, done0, e.d0, e.s);
        end
      end
    end
  end
  task automatic launch(input logic [15:0] v);
    start = 1'b1;
    value = v;
    sb.push_back(model(v));
    @(negedge clock);
    start = 1'b0;
    value = 16'($urandom);
  endtask
  task automatic wait_done(output int lat, output int bcnt, output bit stable);
    logic [19:0] held;
    held   = digits;
    stable = 1'b1;
    lat    = 1;
    bcnt   = int'(busy);
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      bcnt += int'(busy);
      if (busy && digits !== held) stable = 1'b0;
    end
  endtask
  task automatic check_timing(input string tag, input int lat, input int bcnt, input bit stable);
    checks++;
    if (lat !== 18) begin
      errors++;
      $display("FAIL %s_latency: done at negedge %0d, required 18", tag, lat);
    end
    checks++;
    if (bcnt !== 17) begin
      errors++;
      $display("FAIL %s_busy_len: busy %0d cycles, required 17", tag, bcnt);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s_hold: digits changed while busy, required stable", tag);
    end
  endtask
  task automatic check_idle(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digits !== 20'hFFFFF || sign_code !== 4'hF ||
        digits0 !== 20'hFFFFF || sign0 !== 4'hF) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b digits=%h sign=%h digits0=%h, required 0 0 fffff f fffff",
               tag, busy, done, digits, sign_code, digits0);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_idle("reset_state");
    reset = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_values();
    logic [15:0] vals[$] = '{16'd0, 16'd12345, 16'hFFF9, 16'h8000, 16'd32767, 16'd9, 16'd10, 16'hFFFF};
    int lat, bcnt;
    bit stable;
    repeat (4) vals.push_back(16'($urandom));
    foreach (vals[k]) begin
      launch(vals[k]);
      wait_done(lat, bcnt, stable);
      check_timing("convert", lat, bcnt, stable);
      @(negedge clock);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_width: done=%b after pulse, required 0", done);
      end
    end
  endtask
  task automatic test_back_to_back();
    int lat, bcnt;
    bit stable;
    launch(16'd4711);
    wait_done(lat, bcnt, stable);
    launch(16'hD8F1);
    wait_done(lat, bcnt, stable);
    check_timing("b2b", lat, bcnt, stable);
    @(negedge clock);
  endtask
  task automatic test_ignore_start();
    int n;
    n = done_cnt;
    launch(16'd12345);
    repeat (4) @(negedge clock);
    start = 1'b1;
    value = 16'd99;
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    checks++;
    if (done_cnt - n !== 1) begin
      errors++;
      $display("FAIL ignore_start: %0d done pulses, required 1", done_cnt - n);
    end
  endtask
  task automatic test_reset_mid();
    int n, lat, bcnt;
    bit stable;
    launch(16'd32767);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    n = done_cnt;
    @(negedge clock);
    reset = 1'b0;
    check_idle("reset_mid");
    repeat (25) @(negedge clock);
    checks++;
    if (done_cnt !== n) begin
      errors++;
      $display("FAIL reset_abort: %0d done pulses after reset, required 0", done_cnt - n);
    end
    launch(16'hFF85);
    wait_done(lat, bcnt, stable);
    check_timing("after_reset", lat, bcnt, stable);
    @(negedge clock);
  endtask
  initial begin
    @(negedge clock);
    test_reset();
    test_values();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
